// File: rtl/adc_mux_pkg.sv
// Shared types and widths for the ADC multiplexer scheduler.
package adc_mux_pkg;

  localparam int unsigned NUM_CH   = 8;
  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned AXIS_W   = 128;
  localparam int unsigned PTR_W    = $clog2(NUM_CH);
  localparam int unsigned HALF_CH  = NUM_CH / 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEND0   = 2'd2,
    SEND1   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/adc_mux_ws_edge.sv
// Word-select rising-edge detector: one history register, combinational pulse.
module adc_mux_ws_edge (
  input  logic sck,
  input  logic rst_n,
  input  logic ws,
  output logic rise_c
);

  logic ws_q;

  // History resets high so a ws already high out of reset is not seen as an edge.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) ws_q <= 1'b1;
    else        ws_q <= ws;
  end

  assign rise_c = ws & ~ws_q;

endmodule

// File: rtl/adc_mux_sched.sv
// Scans 8 ADC channels per ws frame and emits the samples as two 128-bit AXIS beats.
// Define ADC_MUX_SCHED_SIGNEXT_EN to sign-extend samples (zero-extended otherwise).
module adc_mux_sched
  import adc_mux_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                       sck,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       ws,
  input  logic [NUM_CH-1:0]          adc_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
  output logic [NUM_CH-1:0]          adc_ack,
  output logic [AXIS_W-1:0]          m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic [CNT_W-1:0]           frame_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  sched_state_t                     state;
  logic [PTR_W-1:0]                 ptr;
  logic [NUM_CH-1:0]                got;
  logic [NUM_CH-1:0][WORD_W-1:0]    words;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  samples;
  logic [NUM_CH-1:0]                got_set_c;
  logic                             ws_rise_c;
  logic                             cap_c;
  logic                             full_c;
  logic                             drop_c;
  logic                             stop_c;

  adc_mux_ws_edge u_ws_edge (
    .sck    (sck),
    .rst_n  (rst_n),
    .ws     (ws),
    .rise_c (ws_rise_c)
  );

  function automatic logic [WORD_W-1:0] extend(input logic [SAMPLE_W-1:0] s);
`ifdef ADC_MUX_SCHED_SIGNEXT_EN
    return {{(WORD_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
`else
    return {{(WORD_W-SAMPLE_W){1'b0}}, s};
`endif
  endfunction

  assign samples   = adc_data;
  assign cap_c     = adc_valid[ptr] & ~got[ptr];
  assign got_set_c = NUM_CH'(cap_c) << ptr;
  // A capture completing the frame wins over a coincident ws edge.
  assign full_c    = &(got | got_set_c);
  assign drop_c    = ws_rise_c && (got != '0) && !full_c;
  assign stop_c    = !start && (got == '0);

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      got           <= '0;
      words         <= '0;
      adc_ack       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_cnt     <= '0;
      drop_cnt      <= '0;
    end else begin
      adc_ack <= '0;
      case (state)
        IDLE: begin
          if (start && ws_rise_c) state <= COLLECT;
        end
        COLLECT: begin
          if (!drop_c) ptr <= ptr + PTR_W'(1);
          if (got == '1) begin
            state         <= SEND0;
            m_axis_tdata  <= words[HALF_CH-1:0];
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
          end else if (stop_c) begin
            state <= IDLE;
          end else if (drop_c) begin
            got <= '0;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
          end else if (cap_c) begin
            words[ptr] <= extend(samples[ptr]);
            got        <= got | got_set_c;
            adc_ack    <= got_set_c;
          end
        end
        SEND0: begin
          if (m_axis_tready) begin
            state        <= SEND1;
            m_axis_tdata <= words[NUM_CH-1:HALF_CH];
            m_axis_tlast <= 1'b1;
          end
        end
        SEND1: begin
          if (m_axis_tready) begin
            state         <= start ? COLLECT : IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            got           <= '0;
            frame_cnt     <= frame_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_mux_sched.sv
// Directed scoreboard bench for adc_mux_sched.
module tb_adc_mux_sched;
  import adc_mux_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic                       sck = 1'b0;
  logic                       rst_n;
  logic                       start;
  logic                       ws;
  logic [NUM_CH-1:0]          adc_valid;
  logic [NUM_CH*SAMPLE_W-1:0] adc_data;
  logic [NUM_CH-1:0]          adc_ack;
  logic [AXIS_W-1:0]          m_axis_tdata;
  logic                       m_axis_tvalid;
  logic                       m_axis_tlast;
  logic                       m_axis_tready;
  logic [CNT_W-1:0]           frame_cnt;
  logic [CNT_W-1:0]           drop_cnt;

  adc_mux_sched #(.CNT_W(CNT_W)) dut (
    .sck           (sck),
    .rst_n         (rst_n),
    .start         (start),
    .ws            (ws),
    .adc_valid     (adc_valid),
    .adc_data      (adc_data),
    .adc_ack       (adc_ack),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt)
  );

  always #5 sck = ~sck;

  typedef struct packed {
    logic              last;
    logic [AXIS_W-1:0] data;
  } beat_t;

  beat_t             exp_q[$];
  int                tests = 0;
  int                fails = 0;
  logic [NUM_CH-1:0] acks_seen;
  logic [23:0]       smp [NUM_CH];
  logic              prev_v, prev_r, prev_l;
  logic [AXIS_W-1:0] prev_d;
  logic [AXIS_W-1:0] b0, b1;

  task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [23:0] s);
`ifdef ADC_MUX_SCHED_SIGNEXT_EN
    return {{8{s[23]}}, s};
`else
    return {8'h00, s};
`endif
  endfunction

  // Observe outputs at negedge (ADC ack model, scoreboard, hold check), then step to posedge+1.
  task automatic tick();
    beat_t e;
    @(negedge sck);
    if (prev_v && !prev_r) begin
      check("hold_tdata", 129'(m_axis_tdata), 129'(prev_d));
      check("hold_ctl", 129'({m_axis_tvalid, m_axis_tlast}), 129'({1'b1, prev_l}));
    end
    if (m_axis_tvalid && m_axis_tready) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_beat: observed %h expected none", m_axis_tdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", {m_axis_tlast, m_axis_tdata}, e);
      end
    end
    acks_seen = acks_seen | adc_ack;
    adc_valid = adc_valid & ~adc_ack;
    prev_v = m_axis_tvalid;
    prev_r = m_axis_tready;
    prev_l = m_axis_tlast;
    prev_d = m_axis_tdata;
    @(posedge sck);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic present(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) begin
      adc_data[p*24 +: 24] = smp[p];
      adc_valid[p] = 1'b1;
    end
  endtask

  task automatic push_expected();
    exp_q.push_back({1'b0, ext(smp[3]), ext(smp[2]), ext(smp[1]), ext(smp[0])});
    exp_q.push_back({1'b1, ext(smp[7]), ext(smp[6]), ext(smp[5]), ext(smp[4])});
  endtask

  task automatic ws_pulse();
    ws = 1'b1;
    tick();
    ws = 1'b0;
  endtask

  task automatic wait_frames(input logic [CNT_W-1:0] n, input int budget);
    for (int i = 0; i < budget && frame_cnt != n; i++) tick();
    check("frame_cnt", 129'(frame_cnt), 129'(n));
  endtask

  task automatic wait_tvalid(input int budget);
    for (int i = 0; i < budget && !m_axis_tvalid; i++) tick();
    check("tvalid_rise", 129'(m_axis_tvalid), 129'(1'b1));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ws = 1'b0; adc_valid = '0; adc_data = '0;
    m_axis_tready = 1'b0; acks_seen = '0;
    prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0;
    #12;
    check("rst_tdata", 129'(m_axis_tdata), 129'(0));
    check("rst_ctl", 129'({m_axis_tvalid, m_axis_tlast, adc_ack}), 129'(0));
    check("rst_cnts", 129'({frame_cnt, drop_cnt}), 129'(0));
    @(posedge sck); #1;
    rst_n = 1'b1;

    // Reference frame with full-rate sink; valid ignored while idle.
    start = 1'b1; m_axis_tready = 1'b1;
    smp[0] = 24'haaaaaa; smp[1] = 24'hbbbbbb; smp[2] = 24'hcccccc; smp[3] = 24'hdddddd;
    smp[4] = 24'heeeeee; smp[5] = 24'hffffff; smp[6] = 24'h111111; smp[7] = 24'h222222;
    present(0, 7);
    ticks(5);
    check("idle_no_ack", 129'(acks_seen), 129'(0));
`ifdef ADC_MUX_SCHED_SIGNEXT_EN
    b0 = 128'hffdddddd_ffcccccc_ffbbbbbb_ffaaaaaa;
    b1 = 128'h00222222_00111111_ffffffff_ffeeeeee;
`else
    b0 = 128'h00dddddd_00cccccc_00bbbbbb_00aaaaaa;
    b1 = 128'h00222222_00111111_00ffffff_00eeeeee;
`endif
    exp_q.push_back({1'b0, b0});
    exp_q.push_back({1'b1, b1});
    ws_pulse();
    wait_frames(16'd1, 60);
    check("f1_acks", 129'(acks_seen), 129'(8'hff));
    check("f1_drained", 129'(exp_q.size()), 129'(0));

    // Back-pressure in SEND0 for 20 cycles.
    m_axis_tready = 1'b0; acks_seen = '0;
    smp[0] = 24'h800001; smp[1] = 24'h7fffff; smp[2] = 24'h123456; smp[3] = 24'hfedcba;
    smp[4] = 24'h000000; smp[5] = 24'hffffff; smp[6] = 24'h400000; smp[7] = 24'hc00000;
    present(0, 7);
    push_expected();
    wait_tvalid(60);
    ticks(20);
    check("bp_ctl", 129'({m_axis_tvalid, m_axis_tlast}), 129'(2'b10));
    check("bp_data", 129'(m_axis_tdata), 129'({ext(smp[3]), ext(smp[2]), ext(smp[1]), ext(smp[0])}));
    m_axis_tready = 1'b1;
    ticks(2);
    check("bp_back2back", 129'(exp_q.size()), 129'(0));
    check("bp_frame_cnt", 129'(frame_cnt), 129'(16'd2));

    // Partial frame (ch0..5) cut by a ws edge is dropped.
    acks_seen = '0;
    for (int p = 0; p < 8; p++) smp[p] = 24'h0a0000 + 24'(p);
    present(0, 5);
    ticks(24);
    check("drop_acks", 129'(acks_seen), 129'(8'h3f));
    ws_pulse();
    ticks(2);
    check("drop_cnt", 129'(drop_cnt), 129'(16'd1));
    ticks(20);
    check("drop_no_beat", 129'({m_axis_tvalid, frame_cnt}), 129'({1'b0, 16'd2}));

    // start drops mid-frame: frame still completes, then idle with no acks.
    acks_seen = '0;
    for (int p = 0; p < 8; p++) smp[p] = 24'h900000 + 24'(p * 24'h011111);
    present(0, 3);
    ticks(12);
    start = 1'b0;
    ticks(3);
    present(4, 7);
    push_expected();
    wait_frames(16'd3, 60);
    check("stop_acks", 129'(acks_seen), 129'(8'hff));
    check("stop_drained", 129'(exp_q.size()), 129'(0));
    acks_seen = '0;
    present(0, 7);
    ticks(64);
    check("idle_64_no_ack", 129'({acks_seen, m_axis_tvalid}), 129'(0));

    // Reset during SEND1 discards the frame.
    start = 1'b1; m_axis_tready = 1'b0;
    push_expected();
    void'(exp_q.pop_back());
    ws_pulse();
    wait_tvalid(60);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    check("send1_ctl", 129'({m_axis_tvalid, m_axis_tlast}), 129'(2'b11));
    rst_n = 1'b0; prev_v = 1'b0;
    #1;
    check("rst_send1_ctl", 129'({m_axis_tvalid, m_axis_tlast, adc_ack}), 129'(0));
    check("rst_send1_data", 129'(m_axis_tdata), 129'(0));
    check("rst_send1_cnts", 129'({frame_cnt, drop_cnt}), 129'(0));
    ticks(3);
    rst_n = 1'b1;
    acks_seen = '0;
    for (int p = 0; p < 8; p++) smp[p] = 24'h5a5a00 ^ 24'(p * 24'h102030);
    present(0, 7);
    m_axis_tready = 1'b1;
    ticks(20);
    check("post_rst_wait_ws", 129'({acks_seen, m_axis_tvalid}), 129'(0));
    push_expected();
    ws_pulse();
    wait_frames(16'd1, 60);
    check("post_rst_drained", 129'(exp_q.size()), 129'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
